// File: rtl/dms_fir_seq_if.sv
// dms_fir_seq_if: sample, coefficient-config and status signals of the DMS FIR sequencer.
// Output width follows DMS_FIR_SEQ_ROUND_EN (DW when defined, full accumulator otherwise).
interface dms_fir_seq_if #(
    parameter int NTAPS = 4,
    parameter int DW    = 16,
    parameter int CW    = 16
);
    localparam int AW   = $clog2(NTAPS);
    localparam int ACCW = DW + CW + $clog2(NTAPS);
`ifdef DMS_FIR_SEQ_ROUND_EN
    localparam int OUTW = DW;
`else
    localparam int OUTW = ACCW;
`endif
    logic signed [DW-1:0]   smp_in;
    logic                   cfg_we;
    logic [AW-1:0]          cfg_addr;
    logic signed [CW-1:0]   cfg_data;
    logic                   cfg_commit;
    logic signed [OUTW-1:0] out_data;
    logic                   out_valid;
    logic                   busy;
    logic                   overrun;
    logic                   commit_pend;
    modport master (
        output smp_in, cfg_we, cfg_addr, cfg_data, cfg_commit,
        input  out_data, out_valid, busy, overrun, commit_pend
    );
    modport slave (
        input  smp_in, cfg_we, cfg_addr, cfg_data, cfg_commit,
        output out_data, out_valid, busy, overrun, commit_pend
    );
endinterface

// File: rtl/dms_fir_seq.sv
// dms_fir_seq: NTAPS-tap FIR time-shared on one MAC, one result per sample tick, shadowed coefficients.
// Define DMS_FIR_SEQ_ROUND_EN for a rounded, saturated DW-wide output instead of the raw accumulator.
module dms_fir_seq #(
    parameter int                   NTAPS = 4,
    parameter int                   DW    = 16,
    parameter int                   CW    = 16,
    parameter int                   DIV   = 500,
    parameter logic signed [CW-1:0] C0    = CW'(7773),
    parameter logic signed [CW-1:0] C1    = CW'(8641),
    parameter logic signed [CW-1:0] C2    = CW'(8641),
    parameter logic signed [CW-1:0] C3    = CW'(7773)
) (
    input logic          clk,
    input logic          rst,
    dms_fir_seq_if.slave bus
);
    localparam int AW   = $clog2(NTAPS);
    localparam int TW   = $clog2(DIV);
    localparam int PW   = DW + CW;
    localparam int ACCW = PW + $clog2(NTAPS);
`ifdef DMS_FIR_SEQ_ROUND_EN
    localparam int OUTW = DW;
    localparam int RW   = ACCW - CW + 2;
    localparam logic signed [RW-1:0] SMAX = RW'((1 << (DW - 1)) - 1);
    localparam logic signed [RW-1:0] SMIN = -SMAX - RW'(1);
`else
    localparam int OUTW = ACCW;
`endif

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t                 state, state_d;
    logic [TW-1:0]          cnt;
    logic [AW-1:0]          idx;
    logic signed [DW-1:0]   x      [NTAPS];
    logic signed [CW-1:0]   coef_a [NTAPS];
    logic signed [CW-1:0]   coef_s [NTAPS];
    logic signed [ACCW-1:0] acc;
    logic signed [PW-1:0]   prod;
    logic signed [OUTW-1:0] res;
    logic                   tick, start;

    function automatic logic signed [CW-1:0] cinit(input int k);
        return k == 0 ? C0 : k == 1 ? C1 : k == 2 ? C2 : C3;
    endfunction

    assign prod     = PW'(coef_a[idx]) * PW'(x[idx]);
    assign bus.busy = state != IDLE;

`ifdef DMS_FIR_SEQ_ROUND_EN
    logic signed [RW-1:0] rsh;
    always_comb begin
        rsh = RW'(((ACCW + 1)'(acc) + (ACCW + 1)'(1 << (CW - 2))) >>> (CW - 1));
        res = rsh > SMAX ? DW'(SMAX) : rsh < SMIN ? DW'(SMIN) : rsh[DW-1:0];
    end
`else
    assign res = acc;
`endif

    always_comb begin
        tick    = cnt == TW'(DIV - 1);
        start   = tick && state == IDLE;
        state_d = start ? MAC
                : (state == MAC && idx == AW'(NTAPS - 1)) ? DONE
                : state == DONE ? IDLE : state;
    end

    always_ff @(posedge clk) state <= rst ? IDLE : state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt             <= '0;
            idx             <= '0;
            acc             <= '0;
            bus.out_data    <= '0;
            bus.out_valid   <= 1'b0;
            bus.overrun     <= 1'b0;
            bus.commit_pend <= 1'b0;
            for (int k = 0; k < NTAPS; k++) begin
                x[k]      <= '0;
                coef_a[k] <= cinit(k);
                coef_s[k] <= cinit(k);
            end
        end else begin
            cnt             <= tick ? '0 : cnt + TW'(1);
            bus.out_valid   <= state == DONE;
            bus.commit_pend <= (start && bus.commit_pend) ? 1'b0 : bus.commit_pend | bus.cfg_commit;
            if (tick && state != IDLE) bus.overrun <= 1'b1;
            if (state == DONE) bus.out_data <= res;
            if (bus.cfg_we) coef_s[bus.cfg_addr] <= bus.cfg_data;
            if (state == MAC) begin
                acc <= acc + ACCW'(prod);
                idx <= idx + AW'(1);
            end
            if (start) begin
                acc  <= '0;
                idx  <= '0;
                x[0] <= bus.smp_in;
                for (int k = 1; k < NTAPS; k++) x[k] <= x[k-1];
                // a write landing on the applying tick is forwarded so it joins the commit
                if (bus.commit_pend)
                    for (int k = 0; k < NTAPS; k++)
                        coef_a[k] <= (bus.cfg_we && bus.cfg_addr == AW'(k)) ? bus.cfg_data : coef_s[k];
            end
        end
    end
endmodule

// File: tb/tb_dms_fir_seq.sv
// tb_dms_fir_seq: randomized bench for dms_fir_seq against a per-sample FIR reference model.
// A second instance with a too-short tick period exercises overrun.
module tb_dms_fir_seq;
    localparam int NT    = 4;
    localparam int DW    = 16;
    localparam int CW    = 16;
    localparam int AW    = $clog2(NT);
    localparam int DIV   = 16;
    localparam int DIV_O = 4;
    localparam int LAT   = NT + 2;
`ifdef DMS_FIR_SEQ_ROUND_EN
    localparam int OUTW = DW;
`else
    localparam int OUTW = DW + CW + $clog2(NT);
`endif

    typedef struct {int t; longint e;} exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   def_c [NT] = '{7773, 8641, 8641, 7773};
    int   hist [NT];
    int   ca [NT];
    int   cs [NT];
    bit   pend;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    dms_fir_seq_if #(.NTAPS(NT), .DW(DW), .CW(CW)) bif ();
    dms_fir_seq_if #(.NTAPS(NT), .DW(DW), .CW(CW)) oif ();

    dms_fir_seq #(.NTAPS(NT), .DW(DW), .CW(CW), .DIV(DIV)) u_dut (
        .clk(clk), .rst(rst), .bus(bif)
    );
    dms_fir_seq #(.NTAPS(NT), .DW(DW), .CW(CW), .DIV(DIV_O)) u_ovr (
        .clk(clk), .rst(rst), .bus(oif)
    );

    // FIR of one sample instant, then the output transform of the build
    function automatic longint fir(input int h [NT], input int c [NT]);
        longint a = 0;
        for (int k = 0; k < NT; k++) a += longint'(h[k]) * longint'(c[k]);
`ifdef DMS_FIR_SEQ_ROUND_EN
        a = (a + (longint'(1) << (CW - 2))) >>> (CW - 1);
        if (a > 32767) a = 32767;
        if (a < -32768) a = -32768;
`endif
        return a;
    endfunction

    function automatic longint model_tick(input int s);
        if (pend) begin
            ca = cs;
            pend = 0;
        end
        for (int k = NT - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = s;
        return fir(hist, ca);
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bif.smp_in = '0; bif.cfg_we = 1'b0; bif.cfg_addr = '0; bif.cfg_data = '0; bif.cfg_commit = 1'b0;
        oif.smp_in = '0; oif.cfg_we = 1'b0; oif.cfg_addr = '0; oif.cfg_data = '0; oif.cfg_commit = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hist = '{default: 0};
        ca = def_c;
        cs = def_c;
        pend = 0;
    endtask

    task automatic start_sample(input int s, output int t, output longint e);
        while (cyc % DIV != DIV - 1) @(negedge clk);
        bif.smp_in = DW'(s);
        t = cyc;
        e = model_tick(s);
    endtask

    task automatic finish_sample(input int t, input longint e, input string name);
        bit seen = 0;
        for (int k = 0; k < LAT + 2 && !seen; k++) begin
            @(negedge clk);
            bif.smp_in = DW'($urandom);
            if (cyc <= t + LAT - 1) begin
                checks++;
                if (bif.busy !== 1'b1) begin
                    errors++; $display("FAIL %s busy cyc=%0d: got %b expected 1", name, cyc, bif.busy);
                end
            end
            if (bif.out_valid === 1'b1) begin
                seen = 1;
                checks++;
                if (cyc != t + LAT) begin
                    errors++; $display("FAIL %s latency: got %0d expected %0d", name, cyc - t, LAT);
                end
                checks++;
                if (bif.out_data !== OUTW'(e)) begin
                    errors++; $display("FAIL %s data: got %0d expected %0d", name, bif.out_data, e);
                end
                checks++;
                if (bif.busy !== 1'b0) begin
                    errors++; $display("FAIL %s busy_at_valid: got %b expected 0", name, bif.busy);
                end
            end
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL %s timeout: got no out_valid expected one at +%0d", name, LAT);
        end else begin
            @(negedge clk);
            checks++;
            if (bif.out_valid !== 1'b0 || bif.out_data !== OUTW'(e)) begin
                errors++; $display("FAIL %s hold: got valid=%b data=%0d expected 0/%0d", name, bif.out_valid, bif.out_data, e);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bif.out_data !== '0) begin errors++; $display("FAIL rst_out_data: got %0d expected 0", bif.out_data); end
        checks++; if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", bif.out_valid); end
        checks++; if (bif.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", bif.busy); end
        checks++; if (bif.overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b expected 0", bif.overrun); end
        checks++; if (bif.commit_pend !== 1'b0) begin errors++; $display("FAIL rst_commit_pend: got %b expected 0", bif.commit_pend); end
    endtask

    task automatic test_impulse();
        int t;
        longint e;
        do_reset();
        for (int k = 0; k <= NT; k++) begin
            start_sample(k == 0 ? 16384 : 0, t, e);
            finish_sample(t, e, "impulse");
        end
    endtask

    task automatic test_dc();
        int t;
        longint e;
        for (int k = 0; k < NT + 2; k++) begin
            start_sample(32767, t, e);
            finish_sample(t, e, "dc_full");
        end
    endtask

    task automatic test_random();
        int t, a, d;
        longint e;
        for (int k = 0; k < 24; k++) begin
            if (k % 6 == 3) begin
                for (int j = 0; j < NT; j++) begin
                    d = int'($urandom_range(65535)) - 32768;
                    bif.cfg_we = 1'b1; bif.cfg_addr = AW'(j); bif.cfg_data = CW'(d);
                    bif.cfg_commit = (j == NT - 1);
                    cs[j] = d;
                    @(negedge clk);
                end
                pend = 1;
                bif.cfg_we = 1'b0; bif.cfg_commit = 1'b0;
            end
            a = int'($urandom_range(65535)) - 32768;
            start_sample(a, t, e);
            finish_sample(t, e, "random");
        end
    endtask

    task automatic test_retune();
        int t, t2;
        longint e, e2;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            start_sample(int'($urandom_range(65535)) - 32768, t, e);
            finish_sample(t, e, "retune_pre");
        end
        start_sample(-12000, t, e);
        for (int k = 0; k < NT; k++) begin
            @(negedge clk);
            if (k == NT - 1) begin
                checks++;
                if (bif.commit_pend !== 1'b0) begin errors++; $display("FAIL retune_pend_low: got %b expected 0", bif.commit_pend); end
            end
            bif.cfg_we = 1'b1; bif.cfg_addr = AW'(k);
            bif.cfg_data = CW'(k == 0 ? 32767 : 0);
            bif.cfg_commit = (k == NT - 1);
            cs[k] = k == 0 ? 32767 : 0;
        end
        pend = 1;
        @(negedge clk);
        bif.cfg_we = 1'b0; bif.cfg_commit = 1'b0;
        checks++;
        if (bif.commit_pend !== 1'b1) begin errors++; $display("FAIL retune_pend_rise: got %b expected 1", bif.commit_pend); end
        finish_sample(t, e, "retune_current");
        start_sample(20000, t2, e2);
        checks++;
        if (bif.commit_pend !== 1'b1) begin errors++; $display("FAIL retune_pend_hold: got %b expected 1", bif.commit_pend); end
        @(negedge clk);
        checks++;
        if (bif.commit_pend !== 1'b0) begin errors++; $display("FAIL retune_pend_fall: got %b expected 0", bif.commit_pend); end
        finish_sample(t2, e2, "retune_new");
        start_sample(-32768, t2, e2);
        finish_sample(t2, e2, "retune_new2");
    endtask

    task automatic test_write_commit();
        int t;
        longint e;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            start_sample(int'($urandom_range(65535)) - 32768, t, e);
            finish_sample(t, e, "wc_pre");
        end
        bif.cfg_we = 1'b1; bif.cfg_addr = AW'(1); bif.cfg_data = '0; bif.cfg_commit = 1'b1;
        cs[1] = 0;
        pend = 1;
        @(negedge clk);
        bif.cfg_we = 1'b0; bif.cfg_commit = 1'b0;
        @(negedge clk);
        bif.cfg_commit = 1'b1;
        @(negedge clk);
        bif.cfg_commit = 1'b0;
        checks++;
        if (bif.commit_pend !== 1'b1) begin errors++; $display("FAIL wc_pend_double: got %b expected 1", bif.commit_pend); end
        for (int k = 0; k < 3; k++) begin
            start_sample(int'($urandom_range(65535)) - 32768, t, e);
            finish_sample(t, e, "wc_post");
        end
        checks++;
        if (bif.commit_pend !== 1'b0) begin errors++; $display("FAIL wc_pend_clear: got %b expected 0", bif.commit_pend); end
    endtask

    task automatic test_reset_mid_mac();
        int t;
        longint e;
        checks++;
        if (bif.overrun !== 1'b0) begin errors++; $display("FAIL main_no_overrun: got %b expected 0", bif.overrun); end
        start_sample(12345, t, e);
        repeat (2) @(negedge clk);
        checks++;
        if (bif.busy !== 1'b1) begin errors++; $display("FAIL mid_mac_busy: got %b expected 1", bif.busy); end
        do_reset();
        checks++;
        if (bif.out_data !== '0) begin errors++; $display("FAIL mid_mac_out_data: got %0d expected 0", bif.out_data); end
        for (int k = 0; k < LAT + 3; k++) begin
            checks++;
            if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL mid_mac_no_valid cyc=%0d: got %b expected 0", cyc, bif.out_valid); end
            @(negedge clk);
        end
        start_sample(-7777, t, e);
        finish_sample(t, e, "post_reset");
    endtask

    task automatic test_overrun();
        int   oh [NT];
        exp_t q [$];
        int   last = -100;
        int   s;
        bit   due, ovr_exp = 0;
        do_reset();
        oh = '{default: 0};
        for (int n = 0; n < 64; n++) begin
            due = q.size() > 0 && q[0].t + LAT == cyc;
            checks++;
            if (oif.out_valid !== due) begin errors++; $display("FAIL ovr_valid cyc=%0d: got %b expected %b", cyc, oif.out_valid, due); end
            if (due) begin
                checks++;
                if (oif.out_data !== OUTW'(q[0].e)) begin errors++; $display("FAIL ovr_data: got %0d expected %0d", oif.out_data, q[0].e); end
                void'(q.pop_front());
            end
            checks++;
            if (oif.overrun !== ovr_exp) begin errors++; $display("FAIL ovr_flag cyc=%0d: got %b expected %b", cyc, oif.overrun, ovr_exp); end
            s = int'($urandom_range(65535)) - 32768;
            oif.smp_in = DW'(s);
            if (cyc % DIV_O == DIV_O - 1) begin
                if (cyc > last + LAT - 1) begin
                    last = cyc;
                    for (int k = NT - 1; k > 0; k--) oh[k] = oh[k-1];
                    oh[0] = s;
                    q.push_back('{cyc, fir(oh, def_c)});
                end else ovr_exp = 1;
            end
            @(negedge clk);
        end
        do_reset();
        checks++;
        if (oif.overrun !== 1'b0) begin errors++; $display("FAIL ovr_cleared_by_rst: got %b expected 0", oif.overrun); end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_dc();
        test_random();
        test_retune();
        test_write_commit();
        test_reset_mid_mac();
        test_overrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
